dma_copy_engine: RTL and testbench

Word-granular block-copy engine that acts as a bus initiator on the processor's data-memory bus, the master-side counterpart to the data RAM / memory-mapped peripheral responder. It requests the bus from the pipeline, reads each source word through the responder's combinational read path, and writes it to the destination on the following clock edge. Status is reported through `busy`, `done` and `err`, plus an optional interrupt line that sits alongside the timer interrupt.

---
 rtl/dma_copy_engine_if.sv | 20 ++
 rtl/dma_copy_engine.sv | 128 ++++++++++++
 tb/tb_dma_copy_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_engine_if.sv
// dma_copy_engine_if: data-memory bus between the copy engine (master) and the RAM/peripheral responder (slave)
interface dma_copy_engine_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic              bus_en_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [31:0]       bus_wdata_o;
  logic [31:0]       bus_rdata_i;
  modport master (
    output bus_req_o, bus_en_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rdata_i
  );
  modport slave (
    input  bus_req_o, bus_en_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rdata_i
  );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-granular block-copy bus initiator; define DMA_IRQ_EN to enable the sticky completion interrupt irq_o
module dma_copy_engine #(
  parameter int                ADDR_W      = 32,
  parameter int                LEN_W       = 10,
  parameter logic [ADDR_W-1:0] PERIPH_BASE = 32'h40000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  input  logic              irq_clr_i,
  dma_copy_engine_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              irq_o
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d, abort_q, abort_d;
  logic [ADDR_W:0]   len_bytes, src_end, dst_end, base_ext;
  logic              misaligned, out_of_range, bad_cmd, in_xfer;
  assign len_bytes    = {{(ADDR_W-LEN_W-1){1'b0}}, len_i, 2'b00};
  assign src_end      = {1'b0, src_addr_i} + len_bytes;
  assign dst_end      = {1'b0, dst_addr_i} + len_bytes;
  assign base_ext     = {1'b0, PERIPH_BASE};
  assign misaligned   = |src_addr_i[1:0] | |dst_addr_i[1:0];
  // last byte addr+4len-1 reaches the peripheral window exactly when the exclusive end exceeds the base
  assign out_of_range = (len_i != '0) && ((src_end > base_ext) || (dst_end > base_ext));
  assign bad_cmd      = misaligned | out_of_range;
  assign in_xfer      = (state_q == REQ) || (state_q == RD) || (state_q == WR);
  assign err_o        = err_q;
  // next-state, datapath updates and bus/status outputs
  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    err_d            = err_q | (in_xfer & abort_i);
    abort_d          = abort_q | (in_xfer & abort_i);
    bus.bus_req_o    = 1'b0;
    bus.bus_en_o     = 1'b0;
    bus.bus_we_o     = 1'b0;
    bus.bus_addr_o   = '0;
    bus.bus_wdata_o  = '0;
    busy_o           = state_q != IDLE;
    done_o           = state_q == FIN;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          cnt_d   = len_i;
          err_d   = bad_cmd;
          abort_d = 1'b0;
          state_d = (bad_cmd || len_i == '0) ? FIN : REQ;
        end
      end
      REQ: begin
        bus.bus_req_o = 1'b1;
        state_d       = (abort_i || abort_q) ? FIN : bus.bus_gnt_i ? RD : REQ;
      end
      RD: begin
        bus.bus_req_o  = 1'b1;
        bus.bus_en_o   = bus.bus_gnt_i;
        bus.bus_addr_o = bus.bus_gnt_i ? src_q : '0;
        if (bus.bus_gnt_i) begin
          data_d  = bus.bus_rdata_i;
          state_d = WR;
        end
      end
      WR: begin
        bus.bus_req_o   = 1'b1;
        bus.bus_en_o    = bus.bus_gnt_i;
        bus.bus_we_o    = bus.bus_gnt_i;
        bus.bus_addr_o  = bus.bus_gnt_i ? dst_q : '0;
        bus.bus_wdata_o = bus.bus_gnt_i ? data_q : '0;
        if (bus.bus_gnt_i) begin
          src_d   = src_q + ADDR_W'(4);
          dst_d   = dst_q + ADDR_W'(4);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1) || abort_q || abort_i) ? FIN : RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, pointers, counter, data and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end
`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;
  // sticky interrupt: set on completion, cleared by irq_clr_i, set wins a tie
  always_comb irq_d = (state_q == FIN) | (irq_q & ~irq_clr_i);
  // interrupt register
  always_ff @(posedge clk) irq_q <= rst_n ? irq_d : 1'b0;
  assign irq_o = irq_q | (state_q == FIN);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif
endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed checks of dma_copy_engine against a word-addressed RAM responder
module tb_dma_copy_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [9:0]  len = '0;
  logic        abort = 1'b0;
  logic        irq_clr = 1'b0;
  logic        busy, done, err, irq;
  logic        mem_clr = 1'b0;
  logic [31:0] mem [1024];
  logic [1023:0] wrote;
  int          n_run = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  int          start_cyc = 0;
  int          done_total = 0;
  int          done_base = 0;
  int          last_done = -1;
  logic        en_at [64];
  logic        we_at [64];
  logic        req_at [64];
  logic        busy_at [64];
  logic        irq_at [64];
  logic [31:0] addr_at [64];
  logic [31:0] wdata_at [64];
  dma_copy_engine_if #(.ADDR_W(32)) bus ();
  dma_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
    .len_i(len), .abort_i(abort), .irq_clr_i(irq_clr), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .irq_o(irq)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pat(input logic [9:0] i);
    return {16'hC0DE, 6'h0, i};
  endfunction
  assign bus.bus_rdata_i = wrote[bus.bus_addr_o[11:2]] ? mem[bus.bus_addr_o[11:2]] : pat(bus.bus_addr_o[11:2]);
  always @(posedge clk) begin
    if (mem_clr) wrote <= '0;
    else if (bus.bus_en_o && bus.bus_we_o) begin
      mem[bus.bus_addr_o[11:2]]   <= bus.bus_wdata_o;
      wrote[bus.bus_addr_o[11:2]] <= 1'b1;
    end
  end
  always @(posedge clk) ncyc <= ncyc + 1;
  always @(negedge clk) begin
    if (ncyc - start_cyc < 64) begin
      en_at[ncyc - start_cyc]    = bus.bus_en_o;
      we_at[ncyc - start_cyc]    = bus.bus_we_o;
      req_at[ncyc - start_cyc]   = bus.bus_req_o;
      busy_at[ncyc - start_cyc]  = busy;
      irq_at[ncyc - start_cyc]   = irq;
      addr_at[ncyc - start_cyc]  = bus.bus_addr_o;
      wdata_at[ncyc - start_cyc] = bus.bus_wdata_o;
    end
    if (done) begin
      done_total = done_total + 1;
      last_done  = ncyc - start_cyc;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic clr_mem();
    @(posedge clk); #1 mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
  endtask
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n, input int cycles,
                     input int drop_at, input int drop_len, input int abort_at, input int rst_at, input int restart_at);
    @(posedge clk); #1;
    src = s; dst = d; len = n; start = 1'b1; bus.bus_gnt_i = 1'b1; abort = 1'b0;
    start_cyc = ncyc; done_base = done_total;
    for (int c = 1; c < cycles; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (c == restart_at) src = 32'h0000_0F00;
      bus.bus_gnt_i = !(c >= drop_at && c < drop_at + drop_len);
      abort = (c == abort_at);
      rst_n = (c != rst_at);
    end
    @(posedge clk); #1;
    start = 1'b0; bus.bus_gnt_i = 1'b1; abort = 1'b0; rst_n = 1'b1;
  endtask
  function automatic int en_count(input int upto);
    int s = 0;
    for (int k = 0; k < upto; k++) s += int'(en_at[k]);
    return s;
  endfunction
  initial begin
    bus.bus_gnt_i = 1'b1;
    clr_mem();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_bus", {bus.bus_req_o, bus.bus_en_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    // basic copy of 4 words with a stray start in cycle 3 that must be ignored
    run(32'h0, 32'h400, 10'd4, 12, -1, 0, -1, -1, 3);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("b_rd_en%0d", w), en_at[2+2*w], 1'b1);
      check($sformatf("b_rd_we%0d", w), we_at[2+2*w], 1'b0);
      check($sformatf("b_rd_addr%0d", w), addr_at[2+2*w], 32'(4*w));
      check($sformatf("b_wr_we%0d", w), we_at[3+2*w], 1'b1);
      check($sformatf("b_wr_addr%0d", w), addr_at[3+2*w], 32'h400 + 32'(4*w));
      check($sformatf("b_wr_data%0d", w), wdata_at[3+2*w], pat(10'(w)));
      check($sformatf("b_mem%0d", w), mem[10'h100 + 10'(w)], pat(10'(w)));
    end
    check("b_en_cnt", en_count(12), 8);
    check("b_req_c1", req_at[1], 1'b1);
    check("b_req_c9", req_at[9], 1'b1);
    check("b_req_c10", req_at[10], 1'b0);
    check("b_busy_c10", busy_at[10], 1'b1);
    check("b_busy_c11", busy_at[11], 1'b0);
    check("b_done_at", last_done, 10);
    check("b_done_cnt", done_total - done_base, 1);
    check("b_err", err, 1'b0);
`ifdef DMA_IRQ_EN
    check("irq_fin", irq_at[10], 1'b1);
    check("irq_hold", irq_at[11], 1'b1);
    @(posedge clk); #1 irq_clr = 1'b1;
    @(posedge clk); #1 irq_clr = 1'b0;
    @(negedge clk);
    check("irq_clr", irq, 1'b0);
`else
    check("irq_off", irq_at[10], 1'b0);
`endif
    // unaligned source is rejected without touching the bus
    run(32'h2, 32'h400, 10'd2, 4, -1, 0, -1, -1, -1);
    check("ua_err", err, 1'b1);
    check("ua_done_at", last_done, 1);
    check("ua_en_cnt", en_count(4), 0);
    // zero length completes at once and clears the previous error
    run(32'h0, 32'h400, 10'd0, 4, -1, 0, -1, -1, -1);
    check("z_err", err, 1'b0);
    check("z_done_at", last_done, 1);
    check("z_done_cnt", done_total - done_base, 1);
    check("z_en_cnt", en_count(4), 0);
    check("z_busy_c2", busy_at[2], 1'b0);
    // last word would land on PERIPH_BASE
    run(32'h0, 32'h3FFF_FFFC, 10'd2, 4, -1, 0, -1, -1, -1);
    check("rng_err", err, 1'b1);
    check("rng_done_at", last_done, 1);
    check("rng_en_cnt", en_count(4), 0);
    // last word just below PERIPH_BASE is accepted
    run(32'h100, 32'h3FFF_FFFC, 10'd1, 6, -1, 0, -1, -1, -1);
    check("edge_err", err, 1'b0);
    check("edge_done_at", last_done, 4);
    check("edge_wr_addr", addr_at[3], 32'h3FFF_FFFC);
    check("edge_wr_data", wdata_at[3], pat(10'h040));
    // grant lost for three cycles during the write of word 1
    clr_mem();
    run(32'h800, 32'hC00, 10'd4, 16, 5, 3, -1, -1, -1);
    check("g_rd1", addr_at[4], 32'h804);
    check("g_gap", {en_at[5], en_at[6], en_at[7]}, 3'b000);
    check("g_req_gap", req_at[6], 1'b1);
    check("g_replay_we", we_at[8], 1'b1);
    check("g_replay_addr", addr_at[8], 32'hC04);
    check("g_replay_data", wdata_at[8], pat(10'h201));
    check("g_en_cnt", en_count(16), 8);
    check("g_done_at", last_done, 13);
    for (int w = 0; w < 4; w++) check($sformatf("g_mem%0d", w), mem[10'h300 + 10'(w)], pat(10'h200 + 10'(w)));
    // abort during the read of word 2 of a 5-word copy
    clr_mem();
    run(32'h200, 32'h600, 10'd5, 12, -1, 0, 6, -1, -1);
    check("a_done_at", last_done, 8);
    check("a_done_cnt", done_total - done_base, 1);
    check("a_err", err, 1'b1);
    for (int w = 0; w < 3; w++) check($sformatf("a_mem%0d", w), mem[10'h180 + 10'(w)], pat(10'h080 + 10'(w)));
    check("a_untouched", {wrote[10'h183], wrote[10'h184]}, 2'b00);
    check("a_en_cnt", en_count(12), 6);
    // reset asserted during cycle 4 of a transfer
    clr_mem();
    run(32'h0, 32'h400, 10'd4, 8, -1, 0, -1, 4, -1);
    check("r_outs", {busy_at[5], req_at[5], en_at[5], irq_at[5]}, 4'b0000);
    check("r_addr", addr_at[5], 32'h0);
    check("r_done_cnt", done_total - done_base, 0);
    check("r_word0", wrote[10'h100], 1'b1);
    check("r_word1", wrote[10'h101], 1'b0);
    check("r_err", err, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
